// File: rtl/song_sequencer_if.sv
// Handshake/data bundle between the song ROM, the note sequencer and the
// downstream sound, scoring and light stages.
interface song_sequencer_if #(
    parameter int CNT_BITS  = 8,
    parameter int OCT_BITS  = 3,
    parameter int NOTE_BITS = 3,
    parameter int LEN_BITS  = 3
);
    logic                 i_en;
    logic                 i_start;
    logic                 i_pause;
    logic [1:0]           i_mod;
    logic [CNT_BITS-1:0]  i_track_len;
    logic [OCT_BITS-1:0]  i_rom_octave;
    logic [NOTE_BITS-1:0] i_rom_note;
    logic [LEN_BITS-1:0]  i_rom_length;

    logic [CNT_BITS-1:0]  o_rom_addr;
    logic [OCT_BITS-1:0]  o_goal_octave;
    logic [NOTE_BITS-1:0] o_goal_note;
    logic [LEN_BITS-1:0]  o_goal_length;
    logic                 o_note_valid;
    logic                 o_note_start;
    logic                 o_note_over;
    logic                 o_done;
    logic                 o_busy;

    modport slave (
        input  i_en, i_start, i_pause, i_mod, i_track_len,
               i_rom_octave, i_rom_note, i_rom_length,
        output o_rom_addr, o_goal_octave, o_goal_note, o_goal_length,
               o_note_valid, o_note_start, o_note_over, o_done, o_busy
    );

    modport master (
        output i_en, i_start, i_pause, i_mod, i_track_len,
               i_rom_octave, i_rom_note, i_rom_length,
        input  o_rom_addr, o_goal_octave, o_goal_note, o_goal_length,
               o_note_valid, o_note_start, o_note_over, o_done, o_busy
    );
endinterface

// File: rtl/song_sequencer.sv
// Timed note sequencer: walks the song table, holds each note for its scheduled
// duration, inserts a rest gap between notes and reports completion.
module song_sequencer #(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_UNITS = 50,
    parameter int CNT_BITS  = 8,
    parameter int OCT_BITS  = 3,
    parameter int NOTE_BITS = 3,
    parameter int LEN_BITS  = 3
) (
    input  logic              clk,
    input  logic              rst,
    song_sequencer_if.slave   bus
);
    localparam int UNIT_BITS = 9;
    localparam int CYC_BITS  = $clog2(TICK_DIV);

    localparam logic [CYC_BITS-1:0]  CYC_LAST = CYC_BITS'(TICK_DIV - 1);
    localparam logic [UNIT_BITS-1:0] GAP_LOAD = UNIT_BITS'(GAP_UNITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [CNT_BITS-1:0]  r_addr;
    logic [OCT_BITS-1:0]  r_goal_octave;
    logic [NOTE_BITS-1:0] r_goal_note;
    logic [LEN_BITS-1:0]  r_goal_length;
    logic [UNIT_BITS-1:0] r_units;
    logic [CYC_BITS-1:0]  r_cyc;
    logic                 r_note_valid;
    logic                 r_note_start;
    logic                 r_note_over;
    logic                 r_done;
    logic                 r_busy;

    logic [UNIT_BITS-1:0] w_base;
    logic [UNIT_BITS-1:0] w_half;
    logic [UNIT_BITS-1:0] w_dur;
    logic                 w_unit_tick;
    logic                 w_expire;
    logic                 w_more;
    logic                 w_empty;

    // Tempo scaling is applied once, at fetch time, so a mod change mid-note
    // never stretches or shortens the note already playing.
    always_comb begin
        w_base = UNIT_BITS'(1) << bus.i_rom_length;
        w_half = w_base >> 1;
        w_dur  = w_base;
        case (bus.i_mod)
            2'd2:    w_dur = w_base << 1;
            2'd3:    w_dur = (w_half == '0) ? UNIT_BITS'(1) : w_half;
            default: w_dur = w_base;
        endcase
    end

    assign w_unit_tick = (r_cyc == CYC_LAST);
    assign w_expire    = w_unit_tick && (r_units <= UNIT_BITS'(1));
    assign w_more      = ({1'b0, r_addr} + (CNT_BITS+1)'(1)) < {1'b0, bus.i_track_len};
    assign w_empty     = (bus.i_track_len == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_goal_octave <= '0;
            r_goal_note   <= '0;
            r_goal_length <= '0;
            r_units       <= '0;
            r_cyc         <= '0;
            r_note_valid  <= 1'b0;
            r_note_start  <= 1'b0;
            r_note_over   <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            r_note_over  <= 1'b0;
            if (!bus.i_en) begin
                // Abort: goal_* deliberately retained, no note_over for the cut note.
                r_state      <= S_IDLE;
                r_addr       <= '0;
                r_units      <= '0;
                r_cyc        <= '0;
                r_note_valid <= 1'b0;
                r_done       <= 1'b0;
                r_busy       <= 1'b0;
            end else if (!bus.i_pause) begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.i_start) begin
                            if (w_empty) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_FETCH;
                                r_addr  <= '0;
                                r_done  <= 1'b0;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        r_goal_octave <= bus.i_rom_octave;
                        r_goal_note   <= bus.i_rom_note;
                        r_goal_length <= bus.i_rom_length;
                        r_units       <= w_dur;
                        r_cyc         <= '0;
                        r_state       <= S_PLAY;
                        r_note_valid  <= 1'b1;
                        r_note_start  <= 1'b1;
                    end
                    S_PLAY: begin
                        if (w_unit_tick) begin
                            r_cyc <= '0;
                            if (w_expire) begin
                                r_state      <= S_GAP;
                                r_units      <= GAP_LOAD;
                                r_note_valid <= 1'b0;
                                r_note_over  <= 1'b1;
                            end else begin
                                r_units <= r_units - UNIT_BITS'(1);
                            end
                        end else begin
                            r_cyc <= r_cyc + CYC_BITS'(1);
                        end
                    end
                    S_GAP: begin
                        if (w_unit_tick) begin
                            r_cyc <= '0;
                            if (w_expire) begin
                                r_units <= '0;
                                if (w_more) begin
                                    r_addr  <= r_addr + CNT_BITS'(1);
                                    r_state <= S_FETCH;
                                end else begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_units <= r_units - UNIT_BITS'(1);
                            end
                        end else begin
                            r_cyc <= r_cyc + CYC_BITS'(1);
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_note_valid <= 1'b0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_rom_addr    = r_addr;
    assign bus.o_goal_octave = r_goal_octave;
    assign bus.o_goal_note   = r_goal_note;
    assign bus.o_goal_length = r_goal_length;
    assign bus.o_note_valid  = r_note_valid;
    assign bus.o_note_start  = r_note_start;
    assign bus.o_note_over   = r_note_over;
    assign bus.o_done        = r_done;
    assign bus.o_busy        = r_busy;
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: each scenario queues the notes and rests
// it expects, a negedge monitor records what the sequencer actually played.
module tb_song_sequencer;
    localparam int TICK = 4;
    localparam int GAPU = 1;

    typedef struct packed {
        logic [7:0]  addr;
        logic [2:0]  oct;
        logic [2:0]  note;
        logic [2:0]  len;
        logic [15:0] play;
        logic        over;
    } note_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    song_sequencer_if #(.CNT_BITS(8), .OCT_BITS(3), .NOTE_BITS(3), .LEN_BITS(3)) bus ();

    song_sequencer #(
        .TICK_DIV(TICK), .GAP_UNITS(GAPU), .CNT_BITS(8),
        .OCT_BITS(3), .NOTE_BITS(3), .LEN_BITS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [2:0] rom_oct  [0:255];
    logic [2:0] rom_note [0:255];
    logic [2:0] rom_len  [0:255];
    assign bus.i_rom_octave = rom_oct[bus.o_rom_addr];
    assign bus.i_rom_note   = rom_note[bus.o_rom_addr];
    assign bus.i_rom_length = rom_len[bus.o_rom_addr];

    int checks = 0;
    int passes = 0;

    note_t exp_q[$];
    note_t obs_q[$];
    int    exp_gap[$];
    int    obs_gap[$];

    note_t cur;
    int    run;
    int    gap_cnt;
    logic  prev_valid;
    logic  in_gap;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
            prev_valid = 1'b0;
            in_gap = 1'b0;
            gap_cnt = 0;
        end else begin
            if (bus.o_note_start) begin
                if (in_gap) begin
                    obs_gap.push_back(gap_cnt);
                    in_gap = 1'b0;
                end
                cur.addr = bus.o_rom_addr;
                cur.oct  = bus.o_goal_octave;
                cur.note = bus.o_goal_note;
                cur.len  = bus.o_goal_length;
                run = 0;
            end else if (bus.o_done && in_gap) begin
                obs_gap.push_back(gap_cnt);
                in_gap = 1'b0;
            end
            if (bus.o_note_valid) begin
                run++;
            end else if (prev_valid) begin
                cur.play = 16'(run);
                cur.over = bus.o_note_over;
                obs_q.push_back(cur);
            end
            if (bus.o_note_over) begin
                in_gap = 1'b1;
                gap_cnt = 0;
            end
            if (in_gap) gap_cnt++;
            prev_valid = bus.o_note_valid;
        end
    end

    function automatic note_t mk(input int a, input int o, input int n, input int l,
                                 input int p, input int ov);
        note_t r;
        r.addr = 8'(a); r.oct = 3'(o); r.note = 3'(n); r.len = 3'(l);
        r.play = 16'(p); r.over = 1'(ov);
        return r;
    endfunction

    task automatic clear_sb;
        exp_q.delete(); obs_q.delete(); exp_gap.delete(); obs_gap.delete();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && bus.o_done !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_en = 1'b0; bus.i_start = 1'b0; bus.i_pause = 1'b0;
        bus.i_mod = 2'd0; bus.i_track_len = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_rom_addr !== 8'd0) $display("FAIL reset_addr: got %0d want 0", bus.o_rom_addr);
        else passes++;
        checks++;
        if ({bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length} !== 9'd0)
            $display("FAIL reset_goal: got %h want 0", {bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length});
        else passes++;
        checks++;
        if ({bus.o_note_valid, bus.o_note_start, bus.o_note_over, bus.o_done, bus.o_busy} !== 5'd0)
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.o_note_valid, bus.o_note_start, bus.o_note_over, bus.o_done, bus.o_busy});
        else passes++;
        rst = 1'b0;
        bus.i_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        note_t e, o;
        int g;
        clear_sb();
        rom_oct[0] = 3'd3; rom_note[0] = 3'd5; rom_len[0] = 3'd1;
        rom_oct[1] = 3'd6; rom_note[1] = 3'd2; rom_len[1] = 3'd0;
        bus.i_track_len = 8'd2; bus.i_mod = 2'd0;
        exp_q.push_back(mk(0, 3, 5, 1, 8, 1));
        exp_q.push_back(mk(1, 6, 2, 0, 4, 1));
        exp_gap.push_back(GAPU * TICK + 1);
        exp_gap.push_back(GAPU * TICK);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        checks++;
        if ({bus.o_busy, bus.o_note_valid} !== 2'b10)
            $display("FAIL basic_fetch: got busy,valid=%b want 10", {bus.o_busy, bus.o_note_valid});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.o_note_valid, bus.o_note_start} !== 2'b11)
            $display("FAIL basic_first_play: got valid,start=%b want 11", {bus.o_note_valid, bus.o_note_start});
        else passes++;
        wait_done(200);
        checks++;
        if (bus.o_done !== 1'b1) $display("FAIL basic_done: got %b want 1", bus.o_done);
        else passes++;
        checks++;
        if ({bus.o_rom_addr, bus.o_busy} !== {8'd1, 1'b0})
            $display("FAIL basic_end: got addr=%0d busy=%b want addr=1 busy=0", bus.o_rom_addr, bus.o_busy);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_done, bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length} !== {1'b1, 3'd6, 3'd2, 3'd0})
            $display("FAIL basic_hold: got done=%b goal=%0d/%0d/%0d want done=1 goal=6/2/0",
                     bus.o_done, bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length);
        else passes++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL basic_note: got none want addr=%0d play=%0d", e.addr, e.play);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL basic_note: got a%0d o%0d n%0d l%0d p%0d ov%0d want a%0d o%0d n%0d l%0d p%0d ov%0d",
                                      o.addr, o.oct, o.note, o.len, o.play, o.over, e.addr, e.oct, e.note, e.len, e.play, e.over);
                else passes++;
            end
        end
        while (exp_gap.size() != 0) begin
            g = exp_gap.pop_front();
            checks++;
            if (obs_gap.size() == 0) $display("FAIL basic_rest: got none want %0d", g);
            else if (obs_gap[0] !== g) $display("FAIL basic_rest: got %0d want %0d", obs_gap.pop_front(), g);
            else begin void'(obs_gap.pop_front()); passes++; end
        end
    endtask

    task automatic test_tempo;
        int tbl [4][3] = '{'{3, 0, 4}, '{2, 2, 32}, '{1, 1, 8}, '{3, 3, 16}};
        note_t e, o;
        for (int i = 0; i < 4; i++) begin
            clear_sb();
            rom_oct[0] = 3'(i); rom_note[0] = 3'(7 - i); rom_len[0] = 3'(tbl[i][1]);
            bus.i_track_len = 8'd1; bus.i_mod = 2'(tbl[i][0]);
            exp_q.push_back(mk(0, i, 7 - i, tbl[i][1], tbl[i][2], 1));
            bus.i_start = 1'b1;
            @(negedge clk);
            bus.i_start = 1'b0;
            @(negedge clk);
            bus.i_mod = 2'd0;
            wait_done(200);
            repeat (2) @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL tempo_note%0d: got none want play=%0d", i, e.play);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL tempo_note%0d: got a%0d o%0d n%0d l%0d p%0d ov%0d want a%0d o%0d n%0d l%0d p%0d ov%0d",
                                      i, o.addr, o.oct, o.note, o.len, o.play, o.over, e.addr, e.oct, e.note, e.len, e.play, e.over);
                else passes++;
            end
        end
    endtask

    task automatic test_pause;
        note_t e, o;
        logic strobe_seen, goal_moved;
        logic [17:0] snap;
        clear_sb();
        rom_oct[0] = 3'd2; rom_note[0] = 3'd3; rom_len[0] = 3'd1;
        bus.i_track_len = 8'd1; bus.i_mod = 2'd0;
        exp_q.push_back(mk(0, 2, 3, 1, 18, 1));
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_pause = 1'b1;
        snap = {bus.o_rom_addr, bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length, bus.o_note_valid};
        strobe_seen = 1'b0;
        goal_moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_note_start || bus.o_note_over) strobe_seen = 1'b1;
            if ({bus.o_rom_addr, bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length, bus.o_note_valid} !== snap)
                goal_moved = 1'b1;
        end
        bus.i_pause = 1'b0;
        checks++;
        if (strobe_seen !== 1'b0) $display("FAIL pause_strobes: got %b want 0", strobe_seen);
        else passes++;
        checks++;
        if (goal_moved !== 1'b0) $display("FAIL pause_frozen: got %b want 0", goal_moved);
        else passes++;
        wait_done(200);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) $display("FAIL pause_note: got none want play=%0d", e.play);
        else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL pause_note: got p%0d ov%0d want p%0d ov%0d", o.play, o.over, e.play, e.over);
            else passes++;
        end
    endtask

    task automatic test_abort;
        note_t e, o;
        logic over_seen;
        clear_sb();
        rom_oct[0] = 3'd1; rom_note[0] = 3'd1; rom_len[0] = 3'd1;
        rom_oct[1] = 3'd4; rom_note[1] = 3'd4; rom_len[1] = 3'd1;
        bus.i_track_len = 8'd2; bus.i_mod = 2'd0;
        exp_q.push_back(mk(0, 1, 1, 1, 8, 1));
        exp_q.push_back(mk(1, 4, 4, 1, 3, 0));
        exp_q.push_back(mk(0, 1, 1, 1, 8, 1));
        exp_q.push_back(mk(1, 4, 4, 1, 8, 1));
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 100 && !(bus.o_note_start === 1'b1 && bus.o_rom_addr === 8'd1); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        bus.i_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_rom_addr, bus.o_note_valid, bus.o_busy, bus.o_done, bus.o_note_over} !== {8'd0, 4'b0000})
            $display("FAIL abort_idle: got addr=%0d valid=%b busy=%b done=%b over=%b want 0 0 0 0 0",
                     bus.o_rom_addr, bus.o_note_valid, bus.o_busy, bus.o_done, bus.o_note_over);
        else passes++;
        checks++;
        if ({bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length} !== {3'd4, 3'd4, 3'd1})
            $display("FAIL abort_goal: got %0d/%0d/%0d want 4/4/1", bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length);
        else passes++;
        over_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_note_over) over_seen = 1'b1;
        end
        checks++;
        if (over_seen !== 1'b0) $display("FAIL abort_no_over: got %b want 0", over_seen);
        else passes++;
        bus.i_en = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done(200);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL abort_note%0d: got none want addr=%0d", i, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL abort_note%0d: got a%0d o%0d n%0d l%0d p%0d ov%0d want a%0d o%0d n%0d l%0d p%0d ov%0d",
                                      i, o.addr, o.oct, o.note, o.len, o.play, o.over, e.addr, e.oct, e.note, e.len, e.play, e.over);
                else passes++;
            end
        end
    endtask

    task automatic test_empty;
        logic valid_seen;
        clear_sb();
        bus.i_en = 1'b0;
        @(negedge clk);
        bus.i_en = 1'b1;
        bus.i_track_len = 8'd0;
        checks++;
        if (bus.o_done !== 1'b0) $display("FAIL empty_idle: got done=%b want 0", bus.o_done);
        else passes++;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        checks++;
        if ({bus.o_done, bus.o_busy} !== 2'b10)
            $display("FAIL empty_done: got done,busy=%b want 10", {bus.o_done, bus.o_busy});
        else passes++;
        valid_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_note_valid || bus.o_note_start) valid_seen = 1'b1;
        end
        checks++;
        if (valid_seen !== 1'b0) $display("FAIL empty_no_note: got %b want 0", valid_seen);
        else passes++;
    endtask

    task automatic test_async_reset;
        rom_oct[0] = 3'd7; rom_note[0] = 3'd7; rom_len[0] = 3'd0;
        bus.i_track_len = 8'd1; bus.i_mod = 2'd0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 50 && bus.o_note_over !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.o_note_over !== 1'b1) $display("FAIL arst_reach_gap: got over=%b want 1", bus.o_note_over);
        else passes++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_rom_addr, bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length,
             bus.o_note_valid, bus.o_note_start, bus.o_note_over, bus.o_done, bus.o_busy} !== 22'd0)
            $display("FAIL arst_outputs: got addr=%0d goal=%0d/%0d/%0d flags=%b want all 0",
                     bus.o_rom_addr, bus.o_goal_octave, bus.o_goal_note, bus.o_goal_length,
                     {bus.o_note_valid, bus.o_note_start, bus.o_note_over, bus.o_done, bus.o_busy});
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_sb();
    endtask

    task automatic test_back_to_back;
        note_t e, o;
        clear_sb();
        rom_oct[0] = 3'd5; rom_note[0] = 3'd6; rom_len[0] = 3'd0;
        rom_oct[1] = 3'd2; rom_note[1] = 3'd1; rom_len[1] = 3'd0;
        bus.i_track_len = 8'd2; bus.i_mod = 2'd0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, 5, 6, 0, 4, 1));
            exp_q.push_back(mk(1, 2, 1, 0, 4, 1));
        end
        bus.i_start = 1'b1;
        @(negedge clk);
        wait_done(200);
        checks++;
        if ({bus.o_done, bus.o_rom_addr} !== {1'b1, 8'd1})
            $display("FAIL repeat_done: got done=%b addr=%0d want 1 1", bus.o_done, bus.o_rom_addr);
        else passes++;
        @(negedge clk);
        bus.i_start = 1'b0;
        checks++;
        if ({bus.o_done, bus.o_busy, bus.o_rom_addr} !== {2'b01, 8'd0})
            $display("FAIL repeat_refetch: got done=%b busy=%b addr=%0d want 0 1 0",
                     bus.o_done, bus.o_busy, bus.o_rom_addr);
        else passes++;
        @(negedge clk);
        wait_done(200);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL repeat_note%0d: got none want addr=%0d", i, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL repeat_note%0d: got a%0d o%0d n%0d l%0d p%0d ov%0d want a%0d o%0d n%0d l%0d p%0d ov%0d",
                                      i, o.addr, o.oct, o.note, o.len, o.play, o.over, e.addr, e.oct, e.note, e.len, e.play, e.over);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tempo();
        test_pause();
        test_abort();
        test_empty();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
